ws2812_frame_driver: RTL and testbench
======================================

# ws2812_frame_driver

Downstream consumer of the per-LED averaging stage. Captures each `avg_rgb`/`led_id` result into a double-buffered LED colour store. On every frame boundary it serialises the latest complete frame onto a WS2812-compatible single-wire output, which drives the ambilight strip.

## Interface
Parameters:
- `NUM_LEDS`, 30: LEDs on the strip, equal to 2*(num_h+num_v); maximum 256.
- `T_BIT`, 125: clock cycles per data bit (1.25 µs at 100 MHz).
- `T0H`, 40: high cycles for a '0' bit.
- `T1H`, 80: high cycles for a '1' bit.
- `T_RESET`, 30000: low cycles of the latch/reset gap after the last bit.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `avg_rgb`  in  24  {R[23:16], G[15:8], B[7:0]} colour from the averaging stage.
- `led_id`  in  8  target LED index for `avg_rgb`.
- `avg_valid`  in  1  one-cycle strobe; `avg_rgb` and `led_id` are valid this cycle.
- `frame_start`  in  1  one-cycle pulse at each video frame boundary.
- `dout`  out  1  WS2812 serial data.
- `busy`  out  1  high while a frame is being transmitted (LOAD, BIT or LATCH state).
- `frame_done`  out  1  one-cycle pulse when the latch gap completes.

## Operation
- Storage is two banks of `NUM_LEDS` x 24 bits. `wr_bank` receives writes and the other bank is `rd_bank`. Both are inferable as RAM; their contents are undefined after reset.
- Write: when `avg_valid`=1 and `led_id` < `NUM_LEDS`, `avg_rgb` is written to `wr_bank[led_id]`. When `led_id` >= `NUM_LEDS`, the write is silently dropped.
- Swap: a swap toggles the bank select, so the freshly written bank becomes `rd_bank`.
- A write in the same cycle as a swap uses the pre-swap select. That value is therefore part of the frame about to be sent.
- Pending request: a `frame_start` received while `busy`=1 sets `pending`; further pulses do not queue beyond one.
- FSM states: IDLE, LOAD, BIT, LATCH.
  - IDLE: on `frame_start`=1 or `pending`=1, swap banks, clear `pending`, go to LOAD.
  - LOAD: read `rd_bank[0]` into the shift register, reordered as {G,R,B}; set bit index 23 and pixel index 0; go to BIT.
  - BIT: `dout`=1 while the bit counter < `T0H` (for a '0' bit) or < `T1H` (for a '1' bit), else 0. Data is sent MSB first. After `T_BIT` cycles, advance to the next bit.
  - The next pixel is prefetched during the current pixel, so there is no gap between bits or pixels. After bit 0 of pixel `NUM_LEDS`-1, go to LATCH.
  - LATCH: `dout`=0 for `T_RESET` cycles. Then pulse `frame_done` and go to IDLE. If `pending`=1, the FSM proceeds on the next cycle exactly as from IDLE.
- Counters: 16-bit cycle counter, 5-bit bit index, 8-bit pixel index. A parameter set that violates T0H < T1H < T_BIT or T_RESET < 65536 is illegal.

## Timing
- Reset values: `dout`=0, `busy`=0, `frame_done`=0. The state is IDLE with bank select 0 and `pending`=0. Reset takes effect immediately (asynchronously), including mid-frame; no partial bit continues.
- `frame_start` sampled at edge N in IDLE:
  - LOAD occupies cycle N+1.
  - `dout` rises at edge N+2, and `busy`=1 from edge N+1.
- Frame length: `NUM_LEDS`*24*`T_BIT` cycles of data plus `T_RESET` cycles of latch.
- `frame_done` is high for exactly one cycle, at edge N+2+`NUM_LEDS`*24*`T_BIT`+`T_RESET`. `busy` falls at that same edge.
- Back-to-back frames: with `pending` set, the next LOAD starts 1 cycle after `frame_done`.
- `avg_valid` is accepted on every cycle, with no backpressure and no stall in any state.

## Test plan
- Small parameters for the bench: NUM_LEDS=2, T_BIT=10, T0H=3, T1H=7, T_RESET=20.
- Single frame: write id0=24'hFF0000 and id1=24'h0000FF, then pulse `frame_start`.
  - Required `dout`: 8 zeros (G), 8 ones (R), 8 zeros (B) for LED0; then 16 zeros and 8 ones for LED1.
  - Each '1' bit is 7 cycles high; each '0' bit is 3 cycles high.
  - `frame_done` occurs 2+480+20 cycles after `frame_start`.
- Double buffering: during transmission, write id0=24'h00FF00. The current frame must be unchanged; the next frame's LED0 starts with 8 ones.
- Pending request: pulse `frame_start` twice mid-frame. Exactly one extra frame must follow, with its LOAD 1 cycle after `frame_done`.
- Out-of-range write: `led_id`=2 with `avg_valid`=1 must leave both LED values unchanged in the next frame.
- Reset mid-bit: assert `rst_n`=0 while `dout`=1. Required: `dout`, `busy` and `frame_done` go to 0 immediately. After release, there is no output until `frame_start`.
- Same-cycle write and swap: `avg_valid` with id1=24'h123456 in the `frame_start` cycle. That value must appear in the frame just started.

Source files
------------

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver
//
// Collects per-LED colours from the averaging stage into a double-buffered
// colour store. On each frame boundary it swaps the buffers and serialises
// the completed frame onto a WS2812 single-wire line. Pixels go out in
// G,R,B order, MSB first. A latch gap of T_RESET low cycles follows the data.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   avg_rgb      {R,G,B} colour, 8 bits each
//   led_id       LED index for avg_rgb; ids >= NUM_LEDS are ignored
//   avg_valid    one-cycle strobe qualifying avg_rgb/led_id
//   frame_start  one-cycle pulse at each video frame boundary
//   dout         WS2812 serial data
//   busy         high while a frame is being transmitted
//   frame_done   one-cycle pulse when the latch gap completes
//
// Outputs are registered from the current state. They therefore trail the
// state register by one clock.
module ws2812_frame_driver #(
    parameter int NUM_LEDS = 30,
    parameter int T_BIT    = 125,
    parameter int T0H      = 40,
    parameter int T1H      = 80,
    parameter int T_RESET  = 30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] avg_rgb,
    input  logic [7:0]  led_id,
    input  logic        avg_valid,
    input  logic        frame_start,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

    localparam int          DEPTH      = 2 * NUM_LEDS;
    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  NUM_LEDS_W = 9'(NUM_LEDS);
    localparam logic [7:0]  LAST_PIX   = 8'(NUM_LEDS - 1);
    localparam logic [15:0] BIT_LAST   = 16'(T_BIT - 1);
    localparam logic [15:0] RESET_END  = 16'(T_RESET);
    localparam logic [15:0] T0H_W      = 16'(T0H);
    localparam logic [15:0] T1H_W      = 16'(T1H);

    // Both banks live in one array. Bank 1 occupies entries NUM_LEDS and up.
    logic [23:0] mem [DEPTH];
    logic [23:0] ram_q;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [4:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  pix_idx_reg, pix_idx_next;
    logic [23:0] shift_reg, shift_next;
    logic        pending_reg, pending_next;
    logic        bank_sel_reg, bank_sel_next;
    logic        dout_reg, dout_next;
    logic        busy_reg, busy_next;
    logic        frame_done_reg, frame_done_next;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_idx;

    function automatic logic [AW-1:0] mem_addr(input logic bank, input logic [7:0] idx);
        logic [9:0] a;
        a = bank ? (10'(NUM_LEDS) + {2'b00, idx}) : {2'b00, idx};
        return a[AW-1:0];
    endfunction

    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    // Writes always target the bank selected before any swap this cycle.
    assign wr_en   = avg_valid && ({1'b0, led_id} < NUM_LEDS_W);
    assign wr_addr = mem_addr(bank_sel_reg, led_id);

    // The read port prefetches the next pixel of the current frame. In IDLE
    // and LATCH it points at pixel 0. It uses the post-swap bank so that pixel
    // 0 is already in ram_q when LOAD runs.
    always_comb begin
        rd_idx = 8'd0;
        if ((state_reg == S_LOAD || state_reg == S_BIT) && pix_idx_reg != LAST_PIX) begin
            rd_idx = pix_idx_reg + 8'd1;
        end
    end

    assign rd_addr = mem_addr(~bank_sel_next, rd_idx);

    // The address match only happens when a write to pixel 0 coincides with
    // the swap. Forwarding keeps that write in the frame being started.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= avg_rgb;
        end
        ram_q <= (wr_en && wr_addr == rd_addr) ? avg_rgb : mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 16'd0;
            bit_idx_reg    <= 5'd0;
            pix_idx_reg    <= 8'd0;
            shift_reg      <= 24'd0;
            pending_reg    <= 1'b0;
            bank_sel_reg   <= 1'b0;
            dout_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            pix_idx_reg    <= pix_idx_next;
            shift_reg      <= shift_next;
            pending_reg    <= pending_next;
            bank_sel_reg   <= bank_sel_next;
            dout_reg       <= dout_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        pix_idx_next    = pix_idx_reg;
        shift_next      = shift_reg;
        pending_next    = pending_reg;
        bank_sel_next   = bank_sel_reg;
        dout_next       = 1'b0;
        busy_next       = (state_reg != S_IDLE);
        frame_done_next = 1'b0;

        // LOAD is covered here as well, even though the busy output is still low then.
        if (frame_start && state_reg != S_IDLE) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (frame_start || pending_reg) begin
                    bank_sel_next = ~bank_sel_reg;
                    pending_next  = 1'b0;
                    pix_idx_next  = 8'd0;
                    state_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_next   = to_grb(ram_q);
                bit_idx_next = 5'd23;
                pix_idx_next = 8'd0;
                cnt_next     = 16'd0;
                state_next   = S_BIT;
            end
            S_BIT: begin
                dout_next = (cnt_reg < (shift_reg[23] ? T1H_W : T0H_W));
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = 16'd0;
                    if (bit_idx_reg == 5'd0) begin
                        if (pix_idx_reg == LAST_PIX) begin
                            state_next = S_LATCH;
                        end else begin
                            pix_idx_next = pix_idx_reg + 8'd1;
                            bit_idx_next = 5'd23;
                            shift_next   = to_grb(ram_q);
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg - 5'd1;
                        shift_next   = {shift_reg[22:0], 1'b0};
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_LATCH: begin
                // The first LATCH cycle still outputs the last data bit through
                // dout_reg. One extra count keeps the low gap at T_RESET cycles.
                if (cnt_reg == RESET_END) begin
                    cnt_next        = 16'd0;
                    state_next      = S_IDLE;
                    frame_done_next = 1'b1;
                    busy_next       = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dout       = dout_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver using small timing parameters.
// Each frame is recorded cycle by cycle from the frame_start edge. It is then
// decoded into GRB words and compared with hand-computed values.
module tb_ws2812_frame_driver;

    localparam int NUM_LEDS = 2;
    localparam int T_BIT    = 10;
    localparam int T0H      = 3;
    localparam int T1H      = 7;
    localparam int T_RESET  = 20;
    localparam int DATA_END = 2 + NUM_LEDS * 24 * T_BIT;   // 482
    localparam int FD_K     = DATA_END + T_RESET;          // 502

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] avg_rgb;
    logic [7:0]  led_id;
    logic        avg_valid;
    logic        frame_start;
    logic        dout;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ws2812_frame_driver #(
        .NUM_LEDS (NUM_LEDS),
        .T_BIT    (T_BIT),
        .T0H      (T0H),
        .T1H      (T1H),
        .T_RESET  (T_RESET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .avg_rgb     (avg_rgb),
        .led_id      (led_id),
        .avg_valid   (avg_valid),
        .frame_start (frame_start),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a clock edge. Returns just after the following edge.
    task automatic wr(input logic [7:0] id, input logic [23:0] data);
        avg_valid = 1'b1;
        led_id    = id;
        avg_rgb   = data;
        @(posedge clk); #1;
        avg_valid = 1'b0;
    endtask

    // Records one frame. k counts clock edges after the edge N that starts it.
    // sw_*  : write issued in the same cycle as frame_start
    // mw0/1 : writes issued mid-frame (sampled at edges 101 and 102)
    // n_mid : number of frame_start pulses issued mid-frame
    task automatic run_frame(input string tag, input bit do_start,
                             input bit sw_en, input logic [7:0] sw_id, input logic [23:0] sw_data,
                             input bit mw0_en, input logic [7:0] mw0_id, input logic [23:0] mw0_data,
                             input bit mw1_en, input logic [7:0] mw1_id, input logic [23:0] mw1_data,
                             input int n_mid, input logic [23:0] exp0, input logic [23:0] exp1);
        logic        dtr [0:FD_K];
        logic        btr [0:FD_K];
        logic        ftr [0:FD_K];
        logic [23:0] word [0:1];
        int          highs, k0, bad, bbad, fd_first, fd_cnt;
        logic        bitv;

        if (do_start) frame_start = 1'b1;
        if (sw_en) begin
            avg_valid = 1'b1;
            led_id    = sw_id;
            avg_rgb   = sw_data;
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        avg_valid   = 1'b0;
        dtr[0] = dout; btr[0] = busy; ftr[0] = frame_done;

        for (int k = 1; k <= FD_K; k++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            avg_valid   = 1'b0;
            dtr[k] = dout; btr[k] = busy; ftr[k] = frame_done;
            if (k == 100 && mw0_en) begin avg_valid = 1'b1; led_id = mw0_id; avg_rgb = mw0_data; end
            if (k == 101 && mw1_en) begin avg_valid = 1'b1; led_id = mw1_id; avg_rgb = mw1_data; end
            if (k == 150 && n_mid >= 1) frame_start = 1'b1;
            if (k == 300 && n_mid >= 2) frame_start = 1'b1;
        end

        // Decode each bit window. A well-formed bit has a contiguous high run of T0H or T1H cycles.
        bad = 0;
        for (int l = 0; l < 2; l++) begin
            word[l] = 24'd0;
            for (int b = 0; b < 24; b++) begin
                k0 = 2 + (l * 24 + b) * T_BIT;
                highs = 0;
                for (int j = 0; j < T_BIT; j++) highs += (dtr[k0 + j] === 1'b1) ? 1 : 0;
                for (int j = 0; j < T_BIT; j++) if (dtr[k0 + j] !== ((j < highs) ? 1'b1 : 1'b0)) bad++;
                if (highs == T1H) bitv = 1'b1;
                else if (highs == T0H) bitv = 1'b0;
                else begin bitv = 1'b0; bad++; end
                word[l] = {word[l][22:0], bitv};
            end
        end
        if (dtr[0] !== 1'b0) bad++;
        if (dtr[1] !== 1'b0) bad++;
        for (int k = DATA_END; k <= FD_K; k++) if (dtr[k] !== 1'b0) bad++;

        bbad = 0;
        if (btr[0] !== 1'b0) bbad++;
        for (int k = 1; k < FD_K; k++) if (btr[k] !== 1'b1) bbad++;
        if (btr[FD_K] !== 1'b0) bbad++;

        fd_first = 0; fd_cnt = 0;
        for (int k = 0; k <= FD_K; k++) begin
            if (ftr[k] === 1'b1) begin
                fd_cnt++;
                if (fd_first == 0) fd_first = k;
            end
        end

        $display("frame %s: led0_grb=%h led1_grb=%h frame_done_at=%0d", tag, word[0], word[1], fd_first);
        check_val({tag, ".led0"}, 32'(word[0]), 32'(exp0));
        check_val({tag, ".led1"}, 32'(word[1]), 32'(exp1));
        check_val({tag, ".shape"}, 32'(bad), 32'd0);
        check_val({tag, ".busy"}, 32'(bbad), 32'd0);
        check_val({tag, ".fd_time"}, 32'(fd_first), 32'(FD_K));
        check_val({tag, ".fd_count"}, 32'(fd_cnt), 32'd1);
    endtask

    // Counts cycles with busy or dout high over a quiet window.
    task automatic quiet(input string tag, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || dout !== 1'b0) act++;
        end
        $display("quiet %s: active_cycles=%0d", tag, act);
        check_val({tag, ".quiet"}, 32'(act), 32'd0);
    endtask

    initial begin
        int waited;
        bit seen;

        rst_n = 1'b0; avg_rgb = 24'd0; led_id = 8'd0; avg_valid = 1'b0; frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.dout", 32'(dout), 32'd0);
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame A: bank0 = {FF0000, 0000FF}. The mid-frame writes fill the other bank.
        wr(8'd0, 24'hFF0000);
        wr(8'd1, 24'h0000FF);
        run_frame("A", 1'b1, 1'b0, 8'd0, 24'h0,
                  1'b1, 8'd0, 24'h00FF00, 1'b1, 8'd1, 24'h0000FF,
                  0, 24'h00FF00, 24'h0000FF);

        // Frame B: shows the mid-A write. It also carries an out-of-range write and two start pulses.
        run_frame("B", 1'b1, 1'b0, 8'd0, 24'h0,
                  1'b1, 8'd2, 24'hABCDEF, 1'b0, 8'd0, 24'h0,
                  2, 24'hFF0000, 24'h0000FF);

        // Frame C starts by itself one cycle after B's frame_done. Bank0 is unchanged.
        run_frame("C", 1'b0, 1'b0, 8'd0, 24'h0,
                  1'b0, 8'd0, 24'h0, 1'b0, 8'd0, 24'h0,
                  0, 24'h00FF00, 24'h0000FF);
        quiet("after_C", 100);

        // Frame D: a write in the frame_start cycle lands in this frame.
        run_frame("D", 1'b1, 1'b1, 8'd1, 24'h123456,
                  1'b0, 8'd0, 24'h0, 1'b0, 8'd0, 24'h0,
                  0, 24'hFF0000, 24'h341256);

        // Reset while dout is high.
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        waited = 0; seen = 1'b0;
        while (!seen && waited < 50) begin
            @(posedge clk); #1;
            waited++;
            if (dout === 1'b1) seen = 1'b1;
        end
        check_val("mid.dout_seen", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid.rst.dout", 32'(dout), 32'd0);
        check_val("mid.rst.busy", 32'(busy), 32'd0);
        check_val("mid.rst.frame_done", 32'(frame_done), 32'd0);
        $display("reset mid-bit: dout=%b busy=%b frame_done=%b", dout, busy, frame_done);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet("after_rst", 100);

        // Frame F: the bank select has restarted at 0.
        wr(8'd0, 24'h0000FF);
        wr(8'd1, 24'hFF0000);
        run_frame("F", 1'b1, 1'b0, 8'd0, 24'h0,
                  1'b0, 8'd0, 24'h0, 1'b0, 8'd0, 24'h0,
                  0, 24'h0000FF, 24'h00FF00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
